pixel_reorder_group: RTL and testbench

//  Parametrised successor of the fixed 4-lane sensor pixel swap. Buffers a group of G beats of N pixel lanes and re-emits it in a

---
 rtl/pixel_reorder_group.sv | 156 +++++++++++++++
 tb/tb_pixel_reorder_group.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_reorder_group.sv
// Ping-pong group buffer that re-emits each GROUP-beat block of LANES pixels in a mode-selected pixel order.
// Optional status outputs err_short/group_count are present when PIXEL_REORDER_STATUS_EN is defined.
module pixel_reorder_group #(
    parameter int LANES     = 4,
    parameter int GROUP     = 4,
    parameter int DATA_BITS = 10,
    parameter int USER_BITS = 1
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       aclken,
    input  logic [1:0]                 mode,
    input  logic [USER_BITS-1:0]       s_tuser,
    input  logic                       s_tlast,
    input  logic [LANES*DATA_BITS-1:0] s_tdata,
    input  logic                       s_tvalid,
    output logic                       s_tready,
    output logic [USER_BITS-1:0]       m_tuser,
    output logic                       m_tlast,
    output logic [LANES*DATA_BITS-1:0] m_tdata,
    output logic                       m_tvalid,
`ifdef PIXEL_REORDER_STATUS_EN
    output logic                       err_short,
    output logic [31:0]                group_count,
`endif
    input  logic                       m_tready
);

    localparam int BW = LANES * DATA_BITS;
    localparam int P  = LANES * GROUP;
    localparam int CW = $clog2(GROUP);

    typedef logic [CW-1:0] cnt_t;

    // Group storage; only full_q and the counters need reset, contents are qualified by full_q.
    logic [BW-1:0]        beat_q  [2][GROUP];
    logic [USER_BITS-1:0] user_q  [2][GROUP];
    cnt_t                 last_q  [2];
    logic [1:0]           bmode_q [2];
    logic [1:0]           tlast_q;

    logic [1:0] full_q, full_d;
    logic       wr_bank_q, rd_bank_q;
    cnt_t       wr_cnt_q, rd_cnt_q;
    logic [1:0] mode_q;

    logic       wr_fire, wr_end, frame_start;
    logic       rd_fire, rd_end;
    logic [1:0] rd_mode;
    logic [BW-1:0] reord [GROUP];

    function automatic int src_idx(input logic [1:0] m, input int q);
        int s;
        s = q;
        case (m)
            2'd1:    s = (q % GROUP) * LANES + q / GROUP;
            2'd2:    s = P - 1 - q;
            2'd3:    s = ((q ^ 1) < P) ? (q ^ 1) : q;
            default: s = q;
        endcase
        return s;
    endfunction

    assign s_tready    = !areset && !full_q[wr_bank_q];
    assign m_tvalid    = full_q[rd_bank_q];
    assign wr_fire     = aclken && s_tvalid && s_tready;
    assign wr_end      = s_tlast || (wr_cnt_q == cnt_t'(GROUP - 1));
    assign frame_start = s_tuser[0] && (wr_cnt_q == '0);
    assign rd_fire     = aclken && m_tvalid && m_tready;
    assign rd_end      = (rd_cnt_q == last_q[rd_bank_q]);

    // Short groups fall back to bypass whatever mode travelled with them.
    assign rd_mode = (last_q[rd_bank_q] != cnt_t'(GROUP - 1)) ? 2'd0 : bmode_q[rd_bank_q];

    always_comb begin
        full_d = full_q;
        if (rd_fire && rd_end) full_d[rd_bank_q] = 1'b0;
        if (wr_fire && wr_end) full_d[wr_bank_q] = 1'b1;
    end

    always_comb begin
        int src;
        src   = 0;
        reord = '{default: '0};
        for (int q = 0; q < P; q++) begin
            src = src_idx(rd_mode, q);
            reord[cnt_t'(q / LANES)][(q % LANES)*DATA_BITS +: DATA_BITS] =
                beat_q[rd_bank_q][cnt_t'(src / LANES)][(src % LANES)*DATA_BITS +: DATA_BITS];
        end
    end

    assign m_tdata = reord[rd_cnt_q];
    assign m_tuser = user_q[rd_bank_q][rd_cnt_q];
    assign m_tlast = tlast_q[rd_bank_q] && rd_end;

    always_ff @(posedge aclk) begin
        if (areset) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            mode_q    <= 2'd0;
        end else if (aclken) begin
            full_q <= full_d;
            if (wr_fire) begin
                if (frame_start) mode_q <= mode;
                if (wr_end) begin
                    wr_cnt_q  <= '0;
                    wr_bank_q <= ~wr_bank_q;
                end else begin
                    wr_cnt_q <= wr_cnt_q + 1'b1;
                end
            end
            if (rd_fire) begin
                if (rd_end) begin
                    rd_cnt_q  <= '0;
                    rd_bank_q <= ~rd_bank_q;
                end else begin
                    rd_cnt_q <= rd_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (wr_fire) begin
            beat_q[wr_bank_q][wr_cnt_q] <= s_tdata;
            user_q[wr_bank_q][wr_cnt_q] <= s_tuser;
            if (wr_cnt_q == '0) bmode_q[wr_bank_q] <= frame_start ? mode : mode_q;
            if (wr_end) begin
                last_q[wr_bank_q]  <= wr_cnt_q;
                tlast_q[wr_bank_q] <= s_tlast;
            end
        end
    end

`ifdef PIXEL_REORDER_STATUS_EN
    logic        err_short_q;
    logic [31:0] group_count_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            err_short_q   <= 1'b0;
            group_count_q <= 32'd0;
        end else if (aclken) begin
            if (wr_fire && wr_end && (wr_cnt_q != cnt_t'(GROUP - 1))) err_short_q <= 1'b1;
            if (rd_fire && rd_end) group_count_q <= group_count_q + 32'd1;
        end
    end

    assign err_short   = err_short_q;
    assign group_count = group_count_q;
`endif

endmodule

// File: tb/tb_pixel_reorder_group.sv
// Directed bench for pixel_reorder_group (LANES=4, GROUP=4, DATA_BITS=10) plus a randomised scoreboard run.
module tb_pixel_reorder_group;
    localparam int N  = 4;
    localparam int G  = 4;
    localparam int DW = 10;
    localparam int BW = N * DW;

    logic          aclk = 1'b0;
    logic          areset, aclken, s_tlast, s_tvalid, s_tready, m_tlast, m_tvalid, m_tready;
    logic [1:0]    mode;
    logic [0:0]    s_tuser, m_tuser;
    logic [BW-1:0] s_tdata, m_tdata;
`ifdef PIXEL_REORDER_STATUS_EN
    logic          err_short;
    logic [31:0]   group_count;
`endif

    always #5 aclk = ~aclk;

    pixel_reorder_group #(.LANES(N), .GROUP(G), .DATA_BITS(DW), .USER_BITS(1)) dut (
        .aclk(aclk), .areset(areset), .aclken(aclken), .mode(mode),
        .s_tuser(s_tuser), .s_tlast(s_tlast), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tuser(m_tuser), .m_tlast(m_tlast), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
`ifdef PIXEL_REORDER_STATUS_EN
        .err_short(err_short), .group_count(group_count),
`endif
        .m_tready(m_tready)
    );

    typedef struct packed {
        logic [BW-1:0] d;
        logic          u;
        logic          l;
    } beat_t;

    beat_t out_q[$];
    beat_t exp_q[$];
    int    out_cyc[$];
    int    cyc = 0;
    int    checks = 0, passes = 0, fails = 0;
    int    last_wait = 0;
    bit    rnd_ready = 1'b0;

    always @(posedge aclk) cyc <= cyc + 1;

    // An output handshake seen at the falling edge completes on the next rising edge.
    always @(negedge aclk) begin
        if (!areset && aclken && m_tvalid && m_tready) begin
            out_q.push_back(beat_t'{d: m_tdata, u: m_tuser[0], l: m_tlast});
            out_cyc.push_back(cyc);
        end
    end

    function automatic logic [BW-1:0] px4(input int a, input int b, input int c, input int d);
        return {DW'(d), DW'(c), DW'(b), DW'(a)};
    endfunction

    function automatic logic [BW-1:0] seq(input int base);
        return px4(base, base + 1, base + 2, base + 3);
    endfunction

    function automatic int ref_src(input int m, input int q);
        case (m)
            1:       return (q % G) * N + q / G;
            2:       return N * G - 1 - q;
            3:       return q ^ 1;
            default: return q;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
        if (rnd_ready) m_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [BW-1:0] d, input logic u, input logic l, input logic [1:0] md);
        int  n;
        bit  acc;
        n = 0;
        acc = 1'b0;
        s_tdata = d; s_tuser = u; s_tlast = l; mode = md; s_tvalid = 1'b1;
        while (!acc && n < 500) begin
            @(negedge aclk);
            acc = s_tready && aclken;
            tick();
            n++;
        end
        s_tvalid = 1'b0;
        last_wait = n;
        if (!acc) begin
            chk("send_accept", 64'(acc), 64'd1);
            $display("%0d/%0d checks passed", passes, checks);
            $fatal(1, "input handshake timed out");
        end
    endtask

    task automatic wait_out(input int n);
        int k;
        k = 0;
        while (out_q.size() < n && k < 3000) begin
            tick();
            k++;
        end
        chk("out_count", 64'(out_q.size()), 64'(n));
    endtask

    task automatic clear_out();
        out_q.delete();
        out_cyc.delete();
    endtask

    initial begin
        int            stalls, L, em, s;
        bit            frame, tl;
        logic [1:0]    cur_mode, md;
        logic [BW-1:0] ed, sd;
        logic [DW-1:0] pix [16];

        areset = 1'b1; aclken = 1'b1; mode = 2'd0; s_tuser = 1'b0; s_tlast = 1'b0;
        s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b0;
        tick();
        tick();
        chk("reset_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("reset_s_tready", 64'(s_tready), 64'd0);
        areset = 1'b0;
        #1;
        chk("post_reset_s_tready", 64'(s_tready), 64'd1);
`ifdef PIXEL_REORDER_STATUS_EN
        chk("reset_group_count", 64'(group_count), 64'd0);
        chk("reset_err_short", 64'(err_short), 64'd0);
`endif

        // Bypass, two groups, first output one cycle after the 4th beat is accepted.
        m_tready = 1'b1;
        clear_out();
        for (int b = 0; b < 8; b++) begin
            send(seq(4 * b), b == 0, b == 7, 2'd0);
            if (b == 2) chk("lat_before", 64'(m_tvalid), 64'd0);
            if (b == 3) chk("lat_first", 64'(m_tvalid), 64'd1);
        end
        wait_out(8);
        for (int b = 0; b < 8; b++) begin
            chk("bypass_data", 64'(out_q[b].d), 64'(seq(4 * b)));
            chk("bypass_tlast", 64'(out_q[b].l), 64'(b == 7));
        end
        chk("bypass_tuser0", 64'(out_q[0].u), 64'd1);

        // Transpose.
        clear_out();
        for (int b = 0; b < 4; b++) send(seq(4 * b), b == 0, b == 3, 2'd1);
        wait_out(4);
        for (int b = 0; b < 4; b++) chk("transpose_data", 64'(out_q[b].d), 64'(px4(b, b + 4, b + 8, b + 12)));
        chk("transpose_tlast", 64'(out_q[3].l), 64'd1);

        // Pair swap frame whose second group presents a different mode, then a mirror frame.
        clear_out();
        for (int b = 0; b < 4; b++) send(seq(4 * b), b == 0, 1'b0, 2'd3);
        for (int b = 0; b < 4; b++) send(seq(16 + 4 * b), 1'b0, b == 3, 2'd2);
        for (int b = 0; b < 4; b++) send(seq(4 * b), b == 0, b == 3, 2'd2);
        wait_out(12);
        chk("swap_beat0", 64'(out_q[0].d), 64'(px4(1, 0, 3, 2)));
        chk("swap_tuser_b0", 64'(out_q[0].u), 64'd1);
        chk("swap_tuser_b1", 64'(out_q[1].u), 64'd0);
        chk("mode_held_midframe", 64'(out_q[4].d), 64'(px4(17, 16, 19, 18)));
        chk("mirror_beat0", 64'(out_q[8].d), 64'(px4(15, 14, 13, 12)));
        chk("mirror_beat3", 64'(out_q[11].d), 64'(px4(3, 2, 1, 0)));

        // Short group under transpose comes out in bypass order.
        clear_out();
        send(seq(0), 1'b1, 1'b0, 2'd1);
        send(seq(4), 1'b0, 1'b1, 2'd1);
        wait_out(2);
        for (int k = 0; k < 6; k++) tick();
        chk("short_no_extra", 64'(out_q.size()), 64'd2);
        chk("short_beat0", 64'(out_q[0].d), 64'(seq(0)));
        chk("short_beat1", 64'(out_q[1].d), 64'(seq(4)));
        chk("short_tlast0", 64'(out_q[0].l), 64'd0);
        chk("short_tlast1", 64'(out_q[1].l), 64'd1);
`ifdef PIXEL_REORDER_STATUS_EN
        chk("err_short_set", 64'(err_short), 64'd1);
`endif

        // Clock enable low freezes a pending output.
        clear_out();
        m_tready = 1'b0;
        for (int b = 0; b < 4; b++) send(seq(40 + 4 * b), b == 0, b == 3, 2'd0);
        tick();
        chk("hold_valid", 64'(m_tvalid), 64'd1);
        aclken = 1'b0;
        m_tready = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        chk("clken_no_out", 64'(out_q.size()), 64'd0);
        chk("clken_data_held", 64'(m_tdata), 64'(seq(40)));
        aclken = 1'b1;
        wait_out(4);
        chk("clken_beat0", 64'(out_q[0].d), 64'(seq(40)));
        chk("clken_beat3", 64'(out_q[3].d), 64'(seq(52)));

        // Full throughput with both sides always ready.
        clear_out();
        stalls = 0;
        for (int b = 0; b < 16; b++) begin
            send(seq(4 * b), b == 0, b == 15, 2'd0);
            stalls += last_wait - 1;
        end
        chk("tput_in_stalls", 64'(stalls), 64'd0);
        wait_out(16);
        chk("tput_out_span", 64'(out_cyc[15] - out_cyc[0]), 64'd15);
        for (int b = 0; b < 16; b++) chk("tput_data", 64'(out_q[b].d), 64'(seq(4 * b)));

        // Random valid/ready against a scoreboard.
        clear_out();
        exp_q.delete();
        rnd_ready = 1'b1;
        cur_mode = 2'd0;
        for (int g = 0; g < 1000; g++) begin
            frame = (g % 5 == 0);
            L = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, G - 1)) : G;
            tl = (L < G) || ($urandom_range(0, 3) == 0);
            if (frame) cur_mode = 2'($urandom_range(0, 3));
            for (int i = 0; i < 16; i++) pix[i] = DW'($urandom);
            for (int b = 0; b < L; b++) begin
                while ($urandom_range(0, 1) == 1) tick();
                sd = {pix[4*b+3], pix[4*b+2], pix[4*b+1], pix[4*b]};
                md = (frame && b == 0) ? cur_mode : 2'($urandom_range(0, 3));
                send(sd, frame && b == 0, tl && b == L - 1, md);
            end
            em = (L < G) ? 0 : int'(cur_mode);
            for (int b = 0; b < L; b++) begin
                for (int l = 0; l < N; l++) begin
                    s = ref_src(em, b * N + l);
                    ed[l*DW +: DW] = pix[s];
                end
                exp_q.push_back(beat_t'{d: ed, u: frame && b == 0, l: tl && b == L - 1});
            end
        end
        wait_out(exp_q.size());
        rnd_ready = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < exp_q.size() && i < out_q.size() && fails < 10; i++)
            chk("rnd_beat", 64'(out_q[i]), 64'(exp_q[i]));

        // Reset with one full bank and a partial group pending.
        m_tready = 1'b0;
        for (int b = 0; b < 4; b++) send(seq(4 * b), b == 0, 1'b0, 2'd2);
        send(seq(16), 1'b0, 1'b0, 2'd2);
        send(seq(20), 1'b0, 1'b0, 2'd2);
        chk("pre_reset_valid", 64'(m_tvalid), 64'd1);
        areset = 1'b1;
        tick();
        chk("midreset_s_tready", 64'(s_tready), 64'd0);
        chk("midreset_m_tvalid", 64'(m_tvalid), 64'd0);
        areset = 1'b0;
        clear_out();
        m_tready = 1'b1;
        for (int b = 0; b < 4; b++) send(seq(100 + 4 * b), b == 0, b == 3, 2'd0);
        wait_out(4);
        for (int k = 0; k < 10; k++) tick();
        chk("after_reset_count", 64'(out_q.size()), 64'd4);
        for (int b = 0; b < 4; b++) chk("after_reset_data", 64'(out_q[b].d), 64'(seq(100 + 4 * b)));
`ifdef PIXEL_REORDER_STATUS_EN
        chk("group_count_one", 64'(group_count), 64'd1);
        chk("err_short_cleared", 64'(err_short), 64'd0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
